cache_controller: RTL



---
 rtl/cache_pkg.sv | 15 +
 rtl/cache_internal_if.sv | 74 +++++++
 rtl/cache_controller.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the L1 cache control path.
// Controller state encoding and CPU operation codes.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOOKUP    = 2'd1,
    WRITEBACK = 2'd2,
    FETCH     = 2'd3
  } cache_ctl_state_e;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/cache_internal_if.sv
// Control bundle between the cache controller FSM and the cache datapath.
// The controller issues single-cycle strobes; the datapath reports tag/dirty/counter status.
interface cache_internal_if;

  // statistics strobes
  logic count_hit;
  logic count_miss;
  logic count_read;
  logic count_write;
  logic count_writeback;

  // datapath control strobes
  logic process_lru_counters;
  logic perform_write;
  logic set_selected_dirty_bit;
  logic clear_selected_dirty_bit;
  logic clear_selected_valid_bit;
  logic set_hmem_block_address;
  logic use_victim_tag_for_hmem_block_address;
  logic reset_counter;
  logic decrement_counter;
  logic miss_recovery_mode;
  logic finish_new_line_install;

  // datapath status
  logic counter_done;
  logic valid_block_match;
  logic valid_dirty_bit;

  modport controller (
    output count_hit,
    output count_miss,
    output count_read,
    output count_write,
    output count_writeback,
    output process_lru_counters,
    output perform_write,
    output set_selected_dirty_bit,
    output clear_selected_dirty_bit,
    output clear_selected_valid_bit,
    output set_hmem_block_address,
    output use_victim_tag_for_hmem_block_address,
    output reset_counter,
    output decrement_counter,
    output miss_recovery_mode,
    output finish_new_line_install,
    input  counter_done,
    input  valid_block_match,
    input  valid_dirty_bit
  );

  modport datapath (
    input  count_hit,
    input  count_miss,
    input  count_read,
    input  count_write,
    input  count_writeback,
    input  process_lru_counters,
    input  perform_write,
    input  set_selected_dirty_bit,
    input  clear_selected_dirty_bit,
    input  clear_selected_valid_bit,
    input  set_hmem_block_address,
    input  use_victim_tag_for_hmem_block_address,
    input  reset_counter,
    input  decrement_counter,
    input  miss_recovery_mode,
    input  finish_new_line_install,
    output counter_done,
    output valid_block_match,
    output valid_dirty_bit
  );

endinterface

// File: rtl/cache_controller.sv
// L1 cache control FSM: request accept, hit handling, dirty-victim writeback
// and word-by-word line fetch over the hmem handshake. Outputs are decoded from state.
module cache_controller
  import cache_pkg::*;
#(
  parameter bit STATS_EN = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cpu_req_valid,
  input  logic cpu_req_we,
  output logic cpu_req_ready,
  output logic cpu_req_done,
  output logic hmem_valid,
  output logic hmem_we,
  input  logic hmem_ready,
  cache_internal_if.controller ctl
);

  cache_ctl_state_e state_q, state_d;
  logic we_q, we_d;

  logic cnt_hit, cnt_miss, cnt_read, cnt_write, cnt_writeback;
  logic lru, pw, set_dirty, clr_dirty, clr_valid;
  logic set_addr, use_victim, rst_cnt, dec_cnt, recovery, install;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      we_q    <= OP_READ;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    cpu_req_ready = 1'b0;
    cpu_req_done  = 1'b0;
    hmem_valid    = 1'b0;
    hmem_we       = 1'b0;
    cnt_hit       = 1'b0;
    cnt_miss      = 1'b0;
    cnt_read      = 1'b0;
    cnt_write     = 1'b0;
    cnt_writeback = 1'b0;
    lru           = 1'b0;
    pw            = 1'b0;
    set_dirty     = 1'b0;
    clr_dirty     = 1'b0;
    clr_valid     = 1'b0;
    set_addr      = 1'b0;
    use_victim    = 1'b0;
    rst_cnt       = 1'b0;
    dec_cnt       = 1'b0;
    recovery      = 1'b0;
    install       = 1'b0;

    if (!reset_n) begin
      // Held in reset: present the idle face with no strobes.
      state_d       = IDLE;
      cpu_req_ready = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          cpu_req_ready = 1'b1;
          if (cpu_req_valid) begin
            cnt_read  = (cpu_req_we == OP_READ);
            cnt_write = (cpu_req_we == OP_WRITE);
            we_d      = cpu_req_we;
            state_d   = LOOKUP;
          end
        end

        LOOKUP: begin
          if (ctl.valid_block_match) begin
            cnt_hit      = 1'b1;
            lru          = 1'b1;
            cpu_req_done = 1'b1;
            pw           = (we_q == OP_WRITE);
            set_dirty    = (we_q == OP_WRITE);
            state_d      = IDLE;
          end else if (ctl.valid_dirty_bit) begin
            cnt_miss      = 1'b1;
            cnt_writeback = 1'b1;
            set_addr      = 1'b1;
            use_victim    = 1'b1;
            rst_cnt       = 1'b1;
            state_d       = WRITEBACK;
          end else begin
            cnt_miss  = 1'b1;
            set_addr  = 1'b1;
            rst_cnt   = 1'b1;
            clr_valid = 1'b1;
            state_d   = FETCH;
          end
        end

        WRITEBACK: begin
          recovery   = 1'b1;
          hmem_valid = 1'b1;
          hmem_we    = 1'b1;
          if (hmem_ready) begin
            if (!ctl.counter_done) begin
              dec_cnt = 1'b1;
            end else begin
              // Victim fully written: retarget hmem at the requested line.
              clr_dirty = 1'b1;
              clr_valid = 1'b1;
              set_addr  = 1'b1;
              rst_cnt   = 1'b1;
              state_d   = FETCH;
            end
          end
        end

        FETCH: begin
          recovery   = 1'b1;
          hmem_valid = 1'b1;
          if (hmem_ready) begin
            pw = 1'b1;
            if (!ctl.counter_done) begin
              dec_cnt = 1'b1;
            end else begin
              // Replay the lookup; it now hits and completes the request.
              install = 1'b1;
              state_d = LOOKUP;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign ctl.count_hit       = STATS_EN ? cnt_hit       : 1'b0;
  assign ctl.count_miss      = STATS_EN ? cnt_miss      : 1'b0;
  assign ctl.count_read      = STATS_EN ? cnt_read      : 1'b0;
  assign ctl.count_write     = STATS_EN ? cnt_write     : 1'b0;
  assign ctl.count_writeback = STATS_EN ? cnt_writeback : 1'b0;

  assign ctl.process_lru_counters                  = lru;
  assign ctl.perform_write                         = pw;
  assign ctl.set_selected_dirty_bit                = set_dirty;
  assign ctl.clear_selected_dirty_bit              = clr_dirty;
  assign ctl.clear_selected_valid_bit              = clr_valid;
  assign ctl.set_hmem_block_address                = set_addr;
  assign ctl.use_victim_tag_for_hmem_block_address = use_victim;
  assign ctl.reset_counter                         = rst_cnt;
  assign ctl.decrement_counter                     = dec_cnt;
  assign ctl.miss_recovery_mode                    = recovery;
  assign ctl.finish_new_line_install               = install;

endmodule
